// File: rtl/bpi_flash_pkg.sv
// Shared types and default timing for the BPI NOR flash controller.
// The defaults match the ML605 board part: 24-bit word address, 16-bit data.
package bpi_flash_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ACC,
        S_RD_RSP,
        S_WR_SU,
        S_WR_PW,
        S_WR_HD,
        S_WR_RSP,
        S_TURN
    } state_t;

    localparam int DEF_AW       = 24;
    localparam int DEF_DW       = 16;
    localparam int DEF_LENW     = 4;
    localparam int DEF_RD_WAIT  = 8;
    localparam int DEF_PG_WAIT  = 3;
    localparam int DEF_WR_SETUP = 2;
    localparam int DEF_WR_PULSE = 4;
    localparam int DEF_WR_HOLD  = 2;
    localparam int DEF_TURN     = 2;
    localparam int DEF_TIMEOUT  = 255;

endpackage

// File: rtl/bpi_wait_timer.sv
// Loadable phase down-counter plus WAIT-pin stall counter, shared by every phase.
// A load of N makes done rise in the Nth cycle of the phase.
module bpi_wait_timer #(
    parameter int CW      = 16,
    parameter int TW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          stall,
    output logic          done,
    output logic          timeout
);

    logic [CW-1:0] cnt;
    logic [TW-1:0] scnt;

    assign done    = (cnt <= CW'(1));
    assign timeout = done && stall && (scnt == TW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt  <= '0;
            scnt <= '0;
        end else if (load) begin
            cnt  <= load_val;
            scnt <= '0;
        end else begin
            if (!done)
                cnt <= cnt - CW'(1);
            // stall cycles only count once the access time has elapsed
            if (done && stall && !timeout)
                scnt <= scnt + TW'(1);
        end
    end

endmodule

// File: rtl/bpi_flash_ctrl.sv
// Valid/ready word-request front end for an asynchronous parallel NOR flash.
// Generates CE/OE/WE and the split data bus, with page reads, WAIT stretching and timeout.
module bpi_flash_ctrl
    import bpi_flash_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int LENW     = DEF_LENW,
    parameter int RD_WAIT  = DEF_RD_WAIT,
    parameter int PG_WAIT  = DEF_PG_WAIT,
    parameter int WR_SETUP = DEF_WR_SETUP,
    parameter int WR_PULSE = DEF_WR_PULSE,
    parameter int WR_HOLD  = DEF_WR_HOLD,
    parameter int TURN     = DEF_TURN,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [LENW-1:0] req_len,
    input  logic [DW-1:0]   req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_last,
    output logic [AW-1:0]   flash_addr,
    output logic [DW-1:0]   flash_dq_o,
    output logic            flash_dq_oe,
    input  logic [DW-1:0]   flash_dq_i,
    input  logic            flash_wait_i,
    output logic            flash_ce_n,
    output logic            flash_oe_n,
    output logic            flash_we_n
);

    localparam int CW = 16;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state, nxt;
    logic            live;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q, rdata_q;
    logic [LENW-1:0] len_q;
    logic            err_q;
    logic            ld, done, tmo, last_beat, accept;
    logic [CW-1:0]   ld_val;

    bpi_wait_timer #(.CW(CW), .TW(TW), .TIMEOUT(TIMEOUT)) u_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (ld),
        .load_val (ld_val),
        .stall    ((state == S_RD_ACC) && flash_wait_i),
        .done     (done),
        .timeout  (tmo)
    );

    assign req_ready  = (state == S_IDLE) && live;
    assign accept     = req_valid && req_ready;
    assign last_beat  = (len_q == '0) || err_q;
    assign rsp_valid  = (state == S_RD_RSP) || (state == S_WR_RSP);
    assign rsp_last   = ((state == S_RD_RSP) && last_beat) || (state == S_WR_RSP);
    assign rsp_err    = (state == S_RD_RSP) && err_q;
    assign rsp_rdata  = rdata_q;
    assign flash_addr = addr_q;
    assign flash_dq_o = data_q;

    always_comb begin
        nxt    = state;
        ld     = 1'b0;
        ld_val = '0;
        case (state)
            S_IDLE: if (accept) begin
                ld = 1'b1;
                if (req_write) begin
                    nxt    = S_WR_SU;
                    ld_val = CW'(WR_SETUP);
                end else begin
                    nxt    = S_RD_ACC;
                    ld_val = CW'(RD_WAIT);
                end
            end
            S_RD_ACC: if (tmo || (done && !flash_wait_i)) nxt = S_RD_RSP;
            S_RD_RSP: if (rsp_ready) begin
                ld = 1'b1;
                if (last_beat) begin
                    nxt    = S_TURN;
                    ld_val = CW'(TURN);
                end else begin
                    nxt    = S_RD_ACC;
                    ld_val = CW'(PG_WAIT);
                end
            end
            S_WR_SU: if (done) begin
                nxt    = S_WR_PW;
                ld     = 1'b1;
                ld_val = CW'(WR_PULSE);
            end
            S_WR_PW: if (done) begin
                nxt    = S_WR_HD;
                ld     = 1'b1;
                ld_val = CW'(WR_HOLD);
            end
            S_WR_HD: if (done) nxt = S_WR_RSP;
            S_WR_RSP: if (rsp_ready) begin
                nxt    = S_TURN;
                ld     = 1'b1;
                ld_val = CW'(TURN);
            end
            S_TURN: if (done) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset releases them at once.
    always_comb begin
        flash_ce_n  = 1'b1;
        flash_oe_n  = 1'b1;
        flash_we_n  = 1'b1;
        flash_dq_oe = 1'b0;
        case (state)
            S_RD_ACC, S_RD_RSP: begin
                flash_ce_n = 1'b0;
                flash_oe_n = 1'b0;
            end
            S_WR_SU, S_WR_HD: begin
                flash_ce_n  = 1'b0;
                flash_dq_oe = 1'b1;
            end
            S_WR_PW: begin
                flash_ce_n  = 1'b0;
                flash_we_n  = 1'b0;
                flash_dq_oe = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            live    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= nxt;
            live  <= 1'b1;
            if (accept) begin
                addr_q  <= req_addr;
                data_q  <= req_wdata;
                len_q   <= req_write ? '0 : req_len;
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
            if (state == S_RD_ACC) begin
                if (tmo) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end else if (done && !flash_wait_i) begin
                    rdata_q <= flash_dq_i;
                end
            end
            if ((state == S_RD_RSP) && rsp_ready && !last_beat) begin
                addr_q <= addr_q + AW'(1);
                len_q  <= len_q - LENW'(1);
            end
        end
    end

    // The flash must never drive the bus while we do.
    a_no_contention: assert property (@(posedge CLK) disable iff (!RST_N)
        !(!flash_oe_n && flash_dq_oe));

endmodule

// File: tb/tb_bpi_flash_ctrl.sv
// Directed bench for bpi_flash_ctrl: reads, page wrap, write, WAIT stretch/timeout, reset.
module tb_bpi_flash_ctrl;

    logic        CLK, RST_N;
    logic        req_valid, req_ready, req_write;
    logic [23:0] req_addr;
    logic [3:0]  req_len;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_last;
    logic [15:0] rsp_rdata;
    logic [23:0] flash_addr;
    logic [15:0] flash_dq_o, flash_dq_i;
    logic        flash_dq_oe, flash_wait_i, flash_ce_n, flash_oe_n, flash_we_n;

    int checks = 0;
    int errors = 0;
    int oe_cnt, we_cnt, doe_cnt, dq_bad, ce_bad, extra_valid, viol;
    logic [15:0] wr_exp;
    logic [23:0] wr_addr;

    bpi_flash_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_last(rsp_last),
        .flash_addr(flash_addr), .flash_dq_o(flash_dq_o), .flash_dq_oe(flash_dq_oe),
        .flash_dq_i(flash_dq_i), .flash_wait_i(flash_wait_i),
        .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n)
    );

    // flash model: a fixed word at 0x10, otherwise low address bits xor 0x5A5A
    assign flash_dq_i = (flash_addr == 24'h000010) ? 16'hBEEF : (flash_addr[15:0] ^ 16'h5A5A);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial viol = 0;
    always @(negedge CLK) if (!flash_oe_n && flash_dq_oe) viol++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [23:0] a, input logic [3:0] l,
                          input logic [15:0] d);
        int n;
        n = 0;
        while (!req_ready && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk("req_ready_seen", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l; req_wdata = d;
        @(posedge CLK);
        #1 req_valid = 1'b0;
    endtask

    // counts negedges after the accept/handshake edge until rsp_valid shows
    task automatic get_beat(input int max, input int drop_at, output int lat);
        oe_cnt = 0; we_cnt = 0; doe_cnt = 0; dq_bad = 0; lat = -1;
        for (int n = 1; n <= max; n++) begin
            @(negedge CLK);
            if (n == drop_at) flash_wait_i = 1'b0;
            if (rsp_valid) begin
                lat = n;
                break;
            end
            if (!flash_oe_n) oe_cnt++;
            if (!flash_we_n) begin
                we_cnt++;
                if (flash_addr !== wr_addr) dq_bad++;
            end
            if (flash_dq_oe) begin
                doe_cnt++;
                if (flash_dq_o !== wr_exp) dq_bad++;
            end
        end
        chk("beat_seen", 32'(lat > 0), 32'd1);
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = -1; ce_bad = 0; extra_valid = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (req_ready) begin
                n = i;
                break;
            end
            if (!flash_ce_n || !flash_oe_n || !flash_we_n || flash_dq_oe) ce_bad++;
            if (rsp_valid) extra_valid++;
        end
    endtask

    initial begin
        int lat, n, hold_bad;
        logic [23:0] pa [4];
        logic [15:0] pd [4];
        pa[0] = 24'hFFFFFE; pa[1] = 24'hFFFFFF; pa[2] = 24'h000000; pa[3] = 24'h000001;
        pd[0] = 16'hA5A4;   pd[1] = 16'hA5A5;   pd[2] = 16'h5A5A;   pd[3] = 16'h5A5B;

        RST_N = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        req_wdata = '0; rsp_ready = 1'b0; flash_wait_i = 1'b0; wr_exp = '0; wr_addr = '0;

        // reset state
        #3;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_flags", 32'({rsp_err, rsp_last}), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        chk("rst_addr", 32'(flash_addr), 0);
        chk("rst_dq", 32'({flash_dq_o, flash_dq_oe}), 0);
        chk("rst_strobes", 32'({flash_ce_n, flash_oe_n, flash_we_n}), 32'h7);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        #1 chk("ready_pre", 32'(req_ready), 0);
        @(negedge CLK);
        chk("ready_post", 32'(req_ready), 1);

        // single read
        do_req(1'b0, 24'h000010, 4'd0, 16'h0);
        get_beat(50, -1, lat);
        chk("rd1_lat", lat, 9);
        chk("rd1_oe_cycles", oe_cnt, 8);
        chk("rd1_data", 32'(rsp_rdata), 32'hBEEF);
        chk("rd1_last_err", 32'({rsp_last, rsp_err}), 32'h2);
        take();
        wait_idle(n);
        chk("rd1_turn", n, 3);
        chk("rd1_turn_strobes", ce_bad, 0);

        // page read across address wrap, back-pressure on the second beat
        do_req(1'b0, 24'hFFFFFE, 4'd3, 16'h0);
        for (int b = 0; b < 4; b++) begin
            get_beat(50, -1, lat);
            chk("pg_lat", lat, (b == 0) ? 9 : 4);
            chk("pg_addr", 32'(flash_addr), 32'(pa[b]));
            chk("pg_data", 32'(rsp_rdata), 32'(pd[b]));
            chk("pg_last", 32'(rsp_last), 32'(b == 3));
            if (b == 1) begin
                hold_bad = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge CLK);
                    if (!rsp_valid || flash_addr !== pa[1] || rsp_rdata !== pd[1] ||
                        flash_oe_n || flash_ce_n) hold_bad++;
                end
                chk("pg_hold", hold_bad, 0);
            end
            take();
        end
        wait_idle(n);
        chk("pg_turn", n, 3);
        chk("pg_no_extra", extra_valid, 0);

        // single write
        wr_exp = 16'h00AA; wr_addr = 24'h000555;
        do_req(1'b1, 24'h000555, 4'd7, 16'h00AA);
        get_beat(50, -1, lat);
        chk("wr_lat", lat, 9);
        chk("wr_we_cycles", we_cnt, 4);
        chk("wr_dqoe_cycles", doe_cnt, 8);
        chk("wr_bus", dq_bad, 0);
        chk("wr_oe", oe_cnt, 0);
        chk("wr_rsp", 32'({rsp_last, rsp_err}), 32'h2);
        chk("wr_rdata", 32'(rsp_rdata), 0);
        chk("wr_rsp_bus", 32'({flash_ce_n, flash_dq_oe}), 32'h2);
        take();
        wait_idle(n);
        chk("wr_turn", n, 3);

        // WAIT held through 10 stall cycles
        wr_exp = '0; wr_addr = '0;
        flash_wait_i = 1'b1;
        do_req(1'b0, 24'h000020, 4'd0, 16'h0);
        get_beat(100, 18, lat);
        chk("wt_lat", lat, 19);
        chk("wt_data", 32'(rsp_rdata), 32'h5A7A);
        chk("wt_err", 32'(rsp_err), 0);
        take();
        wait_idle(n);

        // WAIT stuck: timeout aborts a 4-word burst
        flash_wait_i = 1'b1;
        do_req(1'b0, 24'h000040, 4'd3, 16'h0);
        get_beat(400, -1, lat);
        chk("to_lat", lat, 263);
        chk("to_err", 32'(rsp_err), 1);
        chk("to_rdata", 32'(rsp_rdata), 0);
        chk("to_last", 32'(rsp_last), 1);
        take();
        wait_idle(n);
        flash_wait_i = 1'b0;
        chk("to_turn", n, 3);
        chk("to_no_extra", extra_valid, 0);

        // reset pulse in the middle of the write pulse
        wr_exp = 16'h1234; wr_addr = 24'h000100;
        do_req(1'b1, 24'h000100, 4'd0, 16'h1234);
        n = 0;
        while (flash_we_n && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("rs_we_seen", 32'(flash_we_n), 0);
        #2 RST_N = 1'b0;
        #1;
        chk("rs_strobes", 32'({flash_ce_n, flash_oe_n, flash_we_n}), 32'h7);
        chk("rs_dqoe", 32'(flash_dq_oe), 0);
        chk("rs_rsp", 32'({rsp_valid, req_ready}), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rs_ready", 32'(req_ready), 1);
        chk("rs_no_rsp", 32'(rsp_valid), 0);
        wr_exp = '0; wr_addr = '0;
        do_req(1'b0, 24'h000010, 4'd0, 16'h0);
        get_beat(50, -1, lat);
        chk("rs_rd_lat", lat, 9);
        chk("rs_rd_data", 32'(rsp_rdata), 32'hBEEF);
        take();
        wait_idle(n);

        chk("no_contention", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
